// File: rtl/z23_mem_responder_if.sv
// Bus and program-load signal bundle between the z23 core/host and the memory responder.
interface z23_mem_responder_if;
  logic [15:0] bus_address;
  logic [7:0]  bus_wdata;
  logic        bus_wr;
  logic [7:0]  bus_rdata;
  logic        load_start;
  logic [15:0] load_addr;
  logic [15:0] load_len;
  logic [7:0]  load_data;
  logic        load_valid;
  logic        load_ready;
  logic        load_done;
  logic        cpu_hold;
  logic        bus_miss;

  modport master (
    output bus_address, bus_wdata, bus_wr,
    output load_start, load_addr, load_len, load_data, load_valid,
    input  bus_rdata, load_ready, load_done, cpu_hold, bus_miss
  );

  modport slave (
    input  bus_address, bus_wdata, bus_wr,
    input  load_start, load_addr, load_len, load_data, load_valid,
    output bus_rdata, load_ready, load_done, cpu_hold, bus_miss
  );
endinterface

// File: rtl/z23_mem_responder.sv
// Byte-wide RAM target for the z23 memory bus with a host load port that
// streams a program image in while the core is held.
module z23_mem_responder #(
  parameter int unsigned DEPTH     = 4096,
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter logic [7:0]  FILL_BYTE = 8'h00
) (
  input  logic               clk,
  input  logic               rst,
  z23_mem_responder_if.slave bus
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, FINISH} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            miss_q, miss_d;
  logic [7:0]      mem_q [DEPTH];

  logic [16:0]     offset;
  logic            hit;
  logic [AW-1:0]   idx;
  logic            hold;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [7:0]      wdata;

  // 17-bit subtraction makes addresses below BASE_ADDR wrap high and miss.
  always_comb begin
    offset = {1'b0, bus.bus_address} - {1'b0, BASE_ADDR};
    hit    = offset < 17'(DEPTH);
    idx    = offset[AW-1:0];
  end

  assign hold = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.load_start) begin
          ptr_d   = bus.load_addr[AW-1:0];
          cnt_d   = bus.load_len;
          state_d = (bus.load_len != 16'd0) ? LOAD : FINISH;
        end
      end
      LOAD: begin
        if (bus.load_valid) begin
          ptr_d = ptr_q + 1'b1;
          cnt_d = cnt_q - 16'd1;
          if (cnt_q == 16'd1) state_d = FINISH;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Single write port: the load path owns it in LOAD, the bus only in IDLE.
  always_comb begin
    we    = 1'b0;
    waddr = idx;
    wdata = bus.bus_wdata;
    if (state_q == LOAD) begin
      we    = bus.load_valid;
      waddr = ptr_q;
      wdata = bus.load_data;
    end else if (state_q == IDLE) begin
      we = bus.bus_wr & hit;
    end
    if (rst) we = 1'b0;
  end

  always_comb begin
    rdata_d = FILL_BYTE;
    miss_d  = ~hit;
    if (hit) rdata_d = (state_q == IDLE && we) ? bus.bus_wdata : mem_q[idx];
    if (hold) begin
      rdata_d = '0;
      miss_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      miss_q  <= miss_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign bus.bus_rdata  = hold ? '0 : rdata_q;
  assign bus.bus_miss   = hold ? 1'b0 : miss_q;
  assign bus.cpu_hold   = hold;
  assign bus.load_ready = (state_q == LOAD);
  assign bus.load_done  = (state_q == FINISH);
endmodule

// File: doc/z23_mem_responder.md
Name: z23_mem_responder

Overview:
Target-side model of the z23 external byte-wide memory bus. It answers the processor's address/data/write-strobe interface from an internal byte RAM and returns read data one cycle later. A host-side load port streams a program image into the RAM before the CPU runs. While a load is in progress, `cpu_hold` keeps the z23 core stalled.

Parameters:
- DEPTH, 4096, number of RAM bytes; must be a power of two, at most 65536.
- BASE_ADDR, 16'h0000, first bus address mapped to RAM byte 0; must be DEPTH-aligned.
- FILL_BYTE, 8'h00, value returned on reads that miss the RAM window.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- bus_address  in  16  byte address from z23 memory_address_out
- bus_wdata  in  8  write data from z23 memory_data_out
- bus_wr  in  1  write strobe from z23 memory_wr; a cycle with bus_wr low is a read
- bus_rdata  out  8  read data to z23 memory_data_in
- load_start  in  1  one-cycle pulse that begins a load
- load_addr  in  16  RAM byte offset of the first loaded byte; sampled with load_start
- load_len  in  16  byte count; sampled with load_start
- load_data  in  8  load byte
- load_valid  in  1  load_data valid
- load_ready  out  1  responder accepts a load byte
- load_done  out  1  one-cycle pulse when the load completes
- cpu_hold  out  1  high while not IDLE; drives the z23 core stall/reset hold
- bus_miss  out  1  registered flag: previous bus cycle addressed outside the window

Behaviour:
- Reset (rst high at a clock edge):
  - outputs: bus_rdata=0, load_ready=0, load_done=0, cpu_hold=0, bus_miss=0.
  - FSM goes to IDLE; pointer and count are cleared.
  - RAM contents are not cleared.
  - Reset during LOAD aborts the load: bytes already written remain, no load_done pulse.
- Window decode:
  - hit = (bus_address - BASE_ADDR) < DEPTH, computed in 17-bit unsigned arithmetic.
  - index = (bus_address - BASE_ADDR)[log2(DEPTH)-1:0].
- Bus access in IDLE:
  - Write: bus_wr=1 and hit writes bus_wdata to RAM[index] at the clock edge.
  - Read: every cycle, bus_rdata is registered with RAM[index] (hit) or FILL_BYTE (miss). Latency is exactly 1 cycle from address to data.
  - Read-during-write to the same index returns the new byte (write-through).
  - A write that misses is dropped.
  - bus_miss is registered as !hit every cycle.
- FSM states: IDLE, LOAD, FINISH.
  - IDLE -> LOAD on load_start with load_len != 0. Latch ptr = load_addr[log2(DEPTH)-1:0] and cnt = load_len.
  - IDLE -> FINISH on load_start with load_len == 0. No RAM writes occur.
  - LOAD:
    - load_ready=1.
    - On load_valid & load_ready: RAM[ptr] = load_data; ptr += 1, wrapping modulo DEPTH; cnt -= 1.
    - When the accepted byte brings cnt to 0, go to FINISH the next cycle.
    - load_valid low: hold state, nothing written.
  - FINISH: load_ready=0, load_done=1 for this single cycle, then IDLE.
- cpu_hold is combinationally (state != IDLE); it is high from the cycle after load_start through FINISH inclusive.
- While cpu_hold=1:
  - bus writes are ignored.
  - bus_rdata is forced to 0 and bus_miss to 0.
  - The load port is the RAM's only writer.
- load_start asserted in LOAD or FINISH is ignored; it is not queued.
- load_start and a bus write in the same IDLE cycle: the bus write completes, and the FSM still enters LOAD.
- load_len > DEPTH is legal; the pointer wraps and later bytes overwrite earlier ones.
- The RAM is a single write port with one synchronous read. The bus and load paths are muxed by state, so there is never a write collision.

Test Plan:
- Reset, then bus write 8'hA5 @ 16'h0010 (bus_wr=1 one cycle), then read 16'h0010 -> bus_rdata=8'hA5 one cycle after the address is presented; bus_miss=0.
- With BASE_ADDR=0 and DEPTH=4096, read 16'h2000 -> bus_rdata=FILL_BYTE (8'h00), bus_miss=1. Write 8'h77 to 16'h2000 -> RAM[0] unchanged (read of 16'h0000 returns its prior value).
- load_start with load_addr=16'h0FFE, load_len=4, bytes 11,22,33,44 with load_valid gaps -> RAM[FFE]=11, RAM[FFF]=22, RAM[000]=33, RAM[001]=44. One load_done pulse. cpu_hold high for exactly the load duration plus the FINISH cycle.
- load_start with load_len=0 -> cpu_hold high for 1 cycle, load_done pulses once, load_ready never high, RAM unchanged.
- Assert rst after 2 of 5 load bytes -> cpu_hold=0 and load_ready=0 the next cycle, no load_done. The 2 written bytes read back; the remaining 3 addresses keep their old values.
- Same-cycle write/read to 16'h0040 with bus_wdata=8'h3C -> bus_rdata=8'h3C the next cycle. A bus write issued during LOAD is not stored.
